// File: rtl/run_ctrl.sv
// CPU run controller: holds the CPU in reset, runs it until halt or cycle budget, keeps run statistics.
// Optional memory-access statistics are built only when RUN_CTRL_MEMSTAT_EN is defined.
module run_ctrl #(
    parameter int CNT_W        = 32,
    parameter int RESET_CYCLES = 4,
    parameter int MAX_CLOCKS   = 1000
) (
    input  logic             InputClk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt,
    input  logic             mem_rd,
    input  logic             mem_wr,
    output logic             cpu_rst,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] CyclesConsumed,
    output logic [CNT_W-1:0] MemAccesses
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RESET = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [7:0]       RST_LAST = 8'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] BUDGET   = CNT_W'(MAX_CLOCKS);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [1:0]       state;
    logic [7:0]       rstCnt;
    logic [CNT_W-1:0] cycNext;
    logic             launch;

    assign launch  = ((state == IDLE) || (state == DONE)) && start;
    assign cycNext = (CyclesConsumed == CNT_MAX) ? CyclesConsumed : CyclesConsumed + ONE;

    always_ff @(posedge InputClk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            rstCnt         <= '0;
            cpu_rst        <= 1'b1;
            running        <= 1'b0;
            done           <= 1'b0;
            timeout        <= 1'b0;
            CyclesConsumed <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= RESET;
                        rstCnt         <= '0;
                        cpu_rst        <= 1'b1;
                        running        <= 1'b0;
                        done           <= 1'b0;
                        timeout        <= 1'b0;
                        CyclesConsumed <= '0;
                    end
                end
                RESET: begin
                    if (rstCnt == RST_LAST) begin
                        state   <= RUN;
                        cpu_rst <= 1'b0;
                        running <= 1'b1;
                    end else begin
                        rstCnt <= rstCnt + 8'd1;
                    end
                end
                RUN: begin
                    // The exit cycle is still counted; halt takes priority over budget timeout.
                    CyclesConsumed <= cycNext;
                    if (halt || (cycNext == BUDGET)) begin
                        state   <= DONE;
                        cpu_rst <= 1'b1;
                        running <= 1'b0;
                        done    <= 1'b1;
                        timeout <= !halt;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cpu_rst <= 1'b1;
                    running <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

`ifdef RUN_CTRL_MEMSTAT_EN
    logic [CNT_W-1:0] memCnt;

    always_ff @(posedge InputClk or negedge rst) begin
        if (!rst) begin
            memCnt <= '0;
        end else if (launch) begin
            memCnt <= '0;
        end else if ((state == RUN) && (mem_rd || mem_wr) && (memCnt != CNT_MAX)) begin
            memCnt <= memCnt + ONE;
        end
    end

    assign MemAccesses = memCnt;
`else
    logic unusedMem;

    assign unusedMem   = mem_rd | mem_wr | launch;
    assign MemAccesses = '0;
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: three instances cover the default budget, a 20-cycle budget and a 4-bit counter build.
module tb_run_ctrl;

`ifdef RUN_CTRL_MEMSTAT_EN
    localparam bit MEM_EN = 1'b1;
`else
    localparam bit MEM_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start [3];
    logic        halt  [3];
    logic        memRd [3];
    logic        memWr [3];
    logic        cpuRst  [3];
    logic        running [3];
    logic        done    [3];
    logic        timeout [3];
    logic [31:0] cycA, memA, cycB, memB;
    logic [3:0]  cycC, memC;

    int nTests = 0;
    int nFail  = 0;
    int n;

    always #5 clk = ~clk;

    run_ctrl #(.CNT_W(32), .RESET_CYCLES(4), .MAX_CLOCKS(1000)) dutA (
        .InputClk(clk), .rst(rst), .start(start[0]), .halt(halt[0]),
        .mem_rd(memRd[0]), .mem_wr(memWr[0]), .cpu_rst(cpuRst[0]),
        .running(running[0]), .done(done[0]), .timeout(timeout[0]),
        .CyclesConsumed(cycA), .MemAccesses(memA)
    );

    run_ctrl #(.CNT_W(32), .RESET_CYCLES(4), .MAX_CLOCKS(20)) dutB (
        .InputClk(clk), .rst(rst), .start(start[1]), .halt(halt[1]),
        .mem_rd(memRd[1]), .mem_wr(memWr[1]), .cpu_rst(cpuRst[1]),
        .running(running[1]), .done(done[1]), .timeout(timeout[1]),
        .CyclesConsumed(cycB), .MemAccesses(memB)
    );

    run_ctrl #(.CNT_W(4), .RESET_CYCLES(4), .MAX_CLOCKS(15)) dutC (
        .InputClk(clk), .rst(rst), .start(start[2]), .halt(halt[2]),
        .mem_rd(memRd[2]), .mem_wr(memWr[2]), .cpu_rst(cpuRst[2]),
        .running(running[2]), .done(done[2]), .timeout(timeout[2]),
        .CyclesConsumed(cycC), .MemAccesses(memC)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start pulse plus the four RESET edges; returns with the instance in RUN.
    task automatic launch(input int k);
        start[k] = 1'b1;
        step();
        start[k] = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0; halt[i] = 1'b0; memRd[i] = 1'b0; memWr[i] = 1'b0;
        end
        rst = 1'b1;
        #2 rst = 1'b0;
        step();
        step();
        chk("rstCpuRst", cpuRst[0], 1);
        chk("rstRunning", running[0], 0);
        chk("rstDone", done[0], 0);
        chk("rstTimeout", timeout[0], 0);
        chk("rstCycles", cycA, 0);
        chk("rstMem", memA, 0);

        rst = 1'b1;
        step();
        step();
        chk("idleAfterRel", cpuRst[0], 1);
        chk("idleNoRun", running[0], 0);

        // Run 1: halt on 10th RUN cycle, start mid-RUN ignored.
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        n = 0;
        while (cpuRst[0] && n < 20) begin
            step();
            n++;
        end
        chk("rstEdges", n, 4);
        chk("runHigh", running[0], 1);
        chk("runCyc0", cycA, 0);
        for (int i = 1; i <= 10; i++) begin
            if (i == 3) start[0] = 1'b1;
            if (i == 10) halt[0] = 1'b1;
            step();
            start[0] = 1'b0;
            halt[0]  = 1'b0;
        end
        chk("haltDone", done[0], 1);
        chk("haltTimeout", timeout[0], 0);
        chk("haltCycles", cycA, 10);
        chk("haltCpuRst", cpuRst[0], 1);
        chk("haltRunning", running[0], 0);

        halt[0] = 1'b1; memRd[0] = 1'b1;
        step();
        step();
        halt[0] = 1'b0; memRd[0] = 1'b0;
        chk("frozenCyc", cycA, 10);
        chk("frozenMem", memA, 0);
        chk("frozenDone", done[0], 1);

        // Run 2: memory access pattern, halt on cycle 12.
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        chk("restartCyc", cycA, 0);
        chk("restartDone", done[0], 0);
        repeat (4) step();
        for (int i = 1; i <= 12; i++) begin
            memRd[0] = (i <= 3) || (i == 6);
            memWr[0] = (i == 4) || (i == 5) || (i == 6);
            halt[0]  = (i == 12);
            step();
        end
        memRd[0] = 1'b0; memWr[0] = 1'b0; halt[0] = 1'b0;
        chk("memCyc", cycA, 12);
        chk("memAcc", memA, MEM_EN ? 6 : 0);

        // Run 3: asynchronous reset mid-RUN, then a fresh run.
        launch(0);
        repeat (7) step();
        chk("midCyc", cycA, 7);
        chk("midRunning", running[0], 1);
        #2 rst = 1'b0;
        #1;
        chk("asyncCyc", cycA, 0);
        chk("asyncCpuRst", cpuRst[0], 1);
        chk("asyncRunning", running[0], 0);
        chk("asyncDone", done[0], 0);
        chk("asyncTimeout", timeout[0], 0);
        #2 rst = 1'b1;
        step();
        step();
        chk("postRstIdle", cpuRst[0], 1);
        chk("postRstCyc", cycA, 0);
        launch(0);
        for (int i = 1; i <= 5; i++) begin
            halt[0] = (i == 5);
            step();
        end
        halt[0] = 1'b0;
        chk("freshCyc", cycA, 5);
        chk("freshDone", done[0], 1);

        // Budget of 20: timeout, then halt exactly on the budget edge.
        launch(1);
        repeat (19) step();
        chk("budget19Done", done[1], 0);
        chk("budget19Cyc", cycB, 19);
        step();
        chk("budgetDone", done[1], 1);
        chk("budgetTimeout", timeout[1], 1);
        chk("budgetCyc", cycB, 20);
        chk("budgetCpuRst", cpuRst[1], 1);
        start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        chk("budgetClrTo", timeout[1], 0);
        chk("budgetClrCyc", cycB, 0);
        repeat (4) step();
        repeat (19) step();
        halt[1] = 1'b1;
        step();
        halt[1] = 1'b0;
        chk("tieDone", done[1], 1);
        chk("tieTimeout", timeout[1], 0);
        chk("tieCyc", cycB, 20);

        // 4-bit counters at full-scale budget with mem_rd held high.
        memRd[2] = 1'b1;
        launch(2);
        repeat (15) step();
        chk("satDone", done[2], 1);
        chk("satTimeout", timeout[2], 1);
        chk("satCyc", cycC, 15);
        chk("satMem", memC, MEM_EN ? 15 : 0);
        step();
        step();
        chk("satHoldCyc", cycC, 15);
        chk("satHoldMem", memC, MEM_EN ? 15 : 0);
        start[2] = 1'b1;
        step();
        start[2] = 1'b0;
        chk("satClrCyc", cycC, 0);
        chk("satClrMem", memC, 0);
        repeat (4) step();
        repeat (15) step();
        chk("satRecntCyc", cycC, 15);
        chk("satRecntMem", memC, MEM_EN ? 15 : 0);
        memRd[2] = 1'b0;

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter CNT_W, default 32: width of both statistic counters.
REQ-002 Parameter RESET_CYCLES, default 4: cycles cpu_rst is held high after start, legal range 1..255.
REQ-003 Parameter MAX_CLOCKS, default 1000: RUN-cycle budget before timeout, legal range 1..2^CNT_W-1.
REQ-004 InputClk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 start  in  1  level, sampled in IDLE/DONE, begins a run.
REQ-007 halt  in  1  CPU halt indication, sampled in RUN.
REQ-008 mem_rd  in  1  CPU memory read strobe (ControlBus[1]).
REQ-009 mem_wr  in  1  CPU memory write strobe (ControlBus[2]).
REQ-010 cpu_rst  out  1  active-high reset driven to the CPU.
REQ-011 running  out  1  high while in RUN.
REQ-012 done  out  1  high while in DONE.
REQ-013 timeout  out  1  high in DONE when the run ended on budget exhaustion.
REQ-014 CyclesConsumed  out  CNT_W  RUN cycles counted in current/last run.
REQ-015 MemAccesses  out  CNT_W  RUN cycles with mem_rd|mem_wr in current/last run.

Function
REQ-016 FSM states SHALL be IDLE, RESET, RUN, DONE; all outputs registered.
REQ-017 IDLE: cpu_rst=1, running=0, done=0; start=1 at an edge -> RESET, counters cleared to 0, timeout cleared.
REQ-018 RESET: cpu_rst=1; internal counter advances each edge; after exactly RESET_CYCLES edges in RESET -> RUN.
REQ-019 RUN: cpu_rst=0, running=1; each edge CyclesConsumed += 1; MemAccesses += 1 when mem_rd|mem_wr.
REQ-020 RUN exit on halt=1: -> DONE, timeout=0; the cycle with halt SHALL still be counted.
REQ-021 RUN exit on budget: the edge at which CyclesConsumed becomes MAX_CLOCKS -> DONE, timeout=1.
REQ-022 halt and budget exhaustion on the same edge: -> DONE, timeout=0 (halt wins); count still reaches MAX_CLOCKS.
REQ-023 DONE: cpu_rst=1, done=1, counters and timeout frozen; start=1 -> RESET with counters and timeout cleared.
REQ-024 start while in RESET or RUN SHALL be ignored.
REQ-025 mem_rd and mem_wr both high in one cycle SHALL count as one access.
REQ-026 Counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-027 halt, mem_rd, mem_wr SHALL be ignored outside RUN.

Reset
REQ-028 rst=0 SHALL immediately force IDLE, cpu_rst=1, running=0, done=0, timeout=0, both counters 0, regardless of state.
REQ-029 Reset deassertion SHALL leave the block in IDLE; a new run requires start.

Configuration
REQ-030 Macro RUN_CTRL_MEMSTAT_EN defined: MemAccesses counter built and behaves per REQ-019/025/026.
REQ-031 Macro RUN_CTRL_MEMSTAT_EN undefined: no MemAccesses register; output tied to 0; mem_rd/mem_wr unused; all other behaviour identical.

Verification
REQ-032 RESET_CYCLES=4, MAX_CLOCKS=1000; start pulse, halt at 10th RUN cycle -> cpu_rst high exactly 4 edges after start, done=1, timeout=0, CyclesConsumed=10.
REQ-033 MAX_CLOCKS=20, halt never -> done=1, timeout=1, CyclesConsumed=20, cpu_rst=1 in DONE.
REQ-034 MAX_CLOCKS=20, halt on 20th RUN cycle -> timeout=0, CyclesConsumed=20.
REQ-035 RUN_CTRL_MEMSTAT_EN defined; 3 cycles mem_rd, 2 mem_wr, 1 both, halt at cycle 12 -> MemAccesses=6; undefined build -> MemAccesses=0.
REQ-036 rst=0 mid-RUN at count 7 (between edges) -> outputs reset immediately, counters 0, state IDLE; start after release -> fresh run from 0.
REQ-037 CNT_W=4, MAX_CLOCKS=15, mem_rd held high -> MemAccesses=15, no wrap; second start from DONE -> counters cleared then recount.
